data_sram_axi_bridge: RTL and testbench
=======================================

// Module: data_sram_axi_bridge
// PURPOSE
//  Converts the CPU data-side SRAM-like port (after MMU translation) into one AXI3 master.
//  Sits directly downstream of the CPU core's data port, in place of the shared dual-port
//  interface, when data traffic gets a dedicated AXI master.
//  Supports one outstanding transaction: single-beat read (AR/R) or single-beat write (AW/W/B).
// PARAMETERS
//  AXI_ID   4'd1  ID driven on arid/awid/wid; rid/bid are not checked (single outstanding).
// PORTS
//  clk        in   1   clock
//  rst        in   1   asynchronous reset, active-high
//  req        in   1   SRAM-like request valid
//  wr         in   1   1 = write, 0 = read; sampled at accept
//  size       in   2   0 = byte, 1 = half, 2 = word; 3 is illegal
//  addr       in   32  physical byte address; sampled at accept
//  wdata      in   32  write data, lane-aligned to addr[1:0]; sampled at accept
//  addr_ok    out  1   request accepted this cycle (req && state == IDLE)
//  data_ok    out  1   one-cycle pulse: read data valid or write complete
//  rdata_o    out  32  read data; valid while data_ok is high, holds its value otherwise
//  bus_err    out  1   sticky: a non-OKAY rresp/bresp was received; cleared only by rst
//  araddr/arsize/arvalid  out 32/3/1   read address channel; arready in 1
//  arid/arlen/arburst/arlock/arcache/arprot  out 4/8/2/2/4/3  = AXI_ID/0/2'b01/0/0/0
//  rid/rdata/rresp/rlast/rvalid  in 4/32/2/1/1; rready out 1   read data channel
//  awaddr/awsize/awvalid  out 32/3/1   write address channel; awready in 1
//  awid/awlen/awburst/awlock/awcache/awprot  out, same constants as AR
//  wid/wdata/wstrb/wlast/wvalid  out 4/32/4/1/1; wready in 1; wlast tied 1
//  bid/bresp/bvalid  in 4/2/1; bready out 1   write response channel
// BEHAVIOUR
//  States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
//  Reset: state IDLE; arvalid, awvalid, wvalid, rready, bready, data_ok, bus_err = 0;
//   rdata_o = 0; latched addr/size/wdata = 0. A reset mid-transaction abandons it silently.
//  IDLE: addr_ok = req (combinational). On req, latch wr, size, addr, wdata and go to
//   RD_ADDR if !wr, else WR_REQ.
//  RD_ADDR: arvalid = 1, araddr = latched addr, arsize = {1'b0,size}. Hold until arready,
//   then go to RD_DATA.
//  RD_DATA: rready = 1. On rvalid, register rdata into rdata_o, OR (rresp != 0) into
//   bus_err, go to DONE. rlast is ignored.
//  WR_REQ: awvalid and wvalid both asserted on entry. Each channel drops its valid
//   independently once handshaken, tracked by aw_done/w_done flags, so either order and
//   simultaneous handshakes all work. When both are done, go to WR_RESP.
//  WR_RESP: bready = 1. On bvalid, OR (bresp != 0) into bus_err, go to DONE.
//  DONE: data_ok = 1 for exactly one cycle, then return to IDLE.
//   addr_ok is low in DONE, so the next request is accepted one cycle after data_ok.
//  Valids are never deasserted before their handshake (AXI rule); addr/data are stable
//   while valid is high.
//  wstrb: size 0 -> 4'b0001 << addr[1:0]; size 1 -> 4'b0011 << {addr[1],1'b0};
//   size 2 -> 4'b1111; size 3 -> 4'b0000 (the transaction still completes).
//  Minimum read latency with ready slaves: accept at T0, arvalid T1, rvalid T2, data_ok T3.
//  Minimum write latency: accept T0, AW/W handshakes T1, bvalid T2, data_ok T3.
//  addr_ok and data_ok never assert in the same cycle. Only one transaction is in flight.
// TESTING
//  Read word 0x1FC0_0004 with ready slave, rdata 0xDEADBEEF -> arsize 3'b010;
//   data_ok at T3 with rdata_o 0xDEADBEEF.
//  Byte write at addr 0x...03, size 0 -> awaddr ...03, wstrb 4'b1000; data_ok one cycle after bvalid.
//  Write where wready rises 3 cycles before awready -> wvalid drops after its handshake,
//   awvalid holds until awready; exactly one data_ok.
//  arready held low 5 cycles -> arvalid and araddr stable throughout; addr_ok low until DONE.
//  rresp = 2'b10 on a read -> data_ok still pulses; bus_err = 1 and stays 1 through later OKAY transactions.
//  Assert rst while in WR_RESP -> all valids/readies 0 and state IDLE immediately (async);
//   the next req is accepted at once.

Source files
------------

// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge
// Bridges the CPU data-side SRAM-like port onto a single AXI3 master.
// At most one single-beat transaction is in flight at a time:
//  - reads use AR then R
//  - writes use AW and W, then B
// CPU-side data ports carry _i/_o suffixes so they stay distinct from the AXI rdata/wdata.
module data_sram_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    // SRAM-like CPU side
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_i,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata_o,
    output logic        bus_err,
    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state_q,   state_d;
    logic [1:0]  size_q,    size_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;

    // Only one transaction is in flight, so rid/bid/rlast carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rlast, bid};

    // Fixed single-beat INCR attributes on both address channels.
    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = AXI_ID;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = AXI_ID;
    assign wlast   = 1'b1;

    // Address/data come straight from the latched request, so they are stable while valid is high.
    assign araddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awaddr = addr_q;
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;

    // All handshake controls decode directly from the registered state and done flags.
    assign arvalid = (state_q == RD_ADDR);
    assign rready  = (state_q == RD_DATA);
    assign awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign bready  = (state_q == WR_RESP);
    assign addr_ok = req && (state_q == IDLE);
    assign data_ok = (state_q == DONE);
    assign rdata_o = rdata_q;
    assign bus_err = bus_err_q;

    // Byte-lane strobes derived from the latched size and low address bits.
    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
            2'd2:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    // Next-state and datapath update for the single-outstanding transaction FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    size_d    = size;
                    addr_d    = addr;
                    wdata_d   = wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rdata_d   = rdata;
                    bus_err_d = bus_err_q | (rresp != 2'b00);
                    state_d   = DONE;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both have handshaken.
                if (awvalid && awready) begin
                    aw_done_d = 1'b1;
                end
                if (wvalid && wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bus_err_d = bus_err_q | (bresp != 2'b00);
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (rst) begin
            state_q   <= IDLE;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// tb_data_sram_axi_bridge
// Directed vector table, hand-written reset sequence, then randomized traffic.
// The bench plays the AXI slave and predicts every output from the bridge's external behaviour.
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata_i;
    logic        addr_ok, data_ok, bus_err;
    logic [31:0] rdata_o;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;
    logic exp_bus_err = 1'b0;

    data_sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata_i(wdata_i),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata_o(rdata_o), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;      // write data, or data the slave returns on a read
        logic [1:0]  resp;
        int          d0;        // read: arready wait   write: awready wait
        int          d1;        // read: rvalid wait    write: wready wait
        int          d2;        // write: bvalid wait
        logic        hold;      // read: keep req high during the transaction
        logic [3:0]  exp_strb;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference strobe: contiguous bytes of the access size, aligned down from the address.
    function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] s;
        int nbytes;
        int base;
        s = 4'b0000;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        base = int'(a) & ~(nbytes - 1);
        for (int b = 0; b < 4; b++) begin
            if (b >= base && b < base + nbytes) s[b] = 1'b1;
        end
        return s;
    endfunction

    task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int ar_wait,
                           input int r_wait, input logic [31:0] d, input logic [1:0] resp,
                           input logic hold);
        req = 1'b1; wr = 1'b0; addr = a; size = sz; wdata_i = $urandom;
        #1 check("rd_addr_ok", addr_ok, 1);
        tick();
        // Scramble CPU inputs to prove the request was latched.
        req = hold; wr = 1'b1; addr = ~a; size = ~sz; wdata_i = $urandom;
        for (int i = 0; i < ar_wait; i++) begin
            arready = 1'b0;
            #1;
            check("ar_stall_valid", arvalid, 1);
            check("ar_stall_addr", araddr, a);
            check("ar_stall_addr_ok", addr_ok, 0);
            tick();
        end
        arready = 1'b1;
        #1;
        check("arvalid", arvalid, 1);
        check("araddr", araddr, a);
        check("arsize", arsize, {1'b0, sz});
        check("ar_const", {arid, arlen, arburst, arlock, arcache, arprot},
              {4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        tick();
        arready = 1'b0;
        for (int i = 0; i < r_wait; i++) begin
            rvalid = 1'b0;
            #1;
            check("r_wait_rready", rready, 1);
            check("r_wait_arvalid", arvalid, 0);
            check("r_wait_data_ok", data_ok, 0);
            tick();
        end
        rvalid = 1'b1; rdata = d; rresp = resp; rlast = 1'b1; rid = 4'd1;
        #1 check("rready", rready, 1);
        check("r_data_ok_early", data_ok, 0);
        tick();
        rvalid = 1'b0; rdata = $urandom; rresp = 2'b00;
        if (resp != 2'b00) exp_bus_err = 1'b1;
        #1;
        check("rd_data_ok", data_ok, 1);
        check("rd_rdata_o", rdata_o, d);
        check("rd_bus_err", bus_err, exp_bus_err);
        check("rd_done_addr_ok", addr_ok, 0);
        tick();
        req = 1'b0;
        #1;
        check("rd_data_ok_pulse", data_ok, 0);
        check("rd_rdata_hold", rdata_o, d);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                            input int aw_wait, input int w_wait, input int b_wait,
                            input logic [1:0] resp, input logic [3:0] strb);
        logic aw_hs, w_hs;
        req = 1'b1; wr = 1'b1; addr = a; size = sz; wdata_i = wd;
        #1 check("wr_addr_ok", addr_ok, 1);
        tick();
        req = 1'b0; wr = 1'b0; addr = $urandom; size = ~sz; wdata_i = ~wd;
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        for (int c = 0; !(aw_hs && w_hs); c++) begin
            awready = (c >= aw_wait);
            wready  = (c >= w_wait);
            #1;
            check("awvalid", awvalid, !aw_hs);
            check("wvalid", wvalid, !w_hs);
            check("wr_req_data_ok", data_ok, 0);
            if (!aw_hs) begin
                check("awaddr", awaddr, a);
                check("awsize", awsize, {1'b0, sz});
            end
            if (!w_hs) begin
                check("wdata", wdata, wd);
                check("wstrb", wstrb, strb);
                check("wlast", wlast, 1);
            end
            if (awready) aw_hs = 1'b1;
            if (wready)  w_hs  = 1'b1;
            tick();
        end
        awready = 1'b0; wready = 1'b0;
        for (int i = 0; i < b_wait; i++) begin
            bvalid = 1'b0;
            #1;
            check("b_wait_bready", bready, 1);
            check("b_wait_valids", {awvalid, wvalid}, 0);
            check("b_wait_data_ok", data_ok, 0);
            tick();
        end
        bvalid = 1'b1; bresp = resp; bid = 4'd1;
        #1 check("bready", bready, 1);
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        if (resp != 2'b00) exp_bus_err = 1'b1;
        #1;
        check("wr_data_ok", data_ok, 1);
        check("wr_bus_err", bus_err, exp_bus_err);
        tick();
        #1 check("wr_data_ok_pulse", data_ok, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd2, 32'h1FC0_0004, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 1'b0, 4'b0000};
        vecs[1] = '{1'b1, 2'd0, 32'h8000_0003, 32'h1100_0000, 2'b00, 0, 0, 0, 1'b0, 4'b1000};
        vecs[2] = '{1'b1, 2'd1, 32'h0000_1002, 32'hBEEF_0000, 2'b00, 3, 0, 2, 1'b0, 4'b1100};
        vecs[3] = '{1'b1, 2'd2, 32'h0000_0010, 32'hA5A5_A5A5, 2'b00, 0, 2, 0, 1'b0, 4'b1111};
        vecs[4] = '{1'b0, 2'd2, 32'h0000_0100, 32'h1234_5678, 2'b00, 5, 1, 0, 1'b1, 4'b0000};
        vecs[5] = '{1'b0, 2'd2, 32'h0000_0200, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 1'b0, 4'b0000};
        vecs[6] = '{1'b1, 2'd3, 32'h0000_0020, 32'h0102_0304, 2'b00, 1, 1, 1, 1'b0, 4'b0000};
        vecs[7] = '{1'b1, 2'd0, 32'h0000_0021, 32'h0000_AB00, 2'b00, 0, 0, 0, 1'b0, 4'b0010};
        vecs[8] = '{1'b0, 2'd0, 32'h0000_0302, 32'h0077_0000, 2'b00, 0, 2, 0, 1'b0, 4'b0000};
        vecs[9] = '{1'b1, 2'd1, 32'h0000_0006, 32'h5566_0000, 2'b01, 2, 2, 1, 1'b0, 4'b1100};

        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata_i = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'b00; bvalid = 1'b0;
        #1;
        check("rst_ctrl", {arvalid, awvalid, wvalid, rready, bready, data_ok, bus_err}, 0);
        check("rst_rdata_o", rdata_o, 0);
        check("rst_latched", araddr | wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].d0, vecs[i].d1,
                         vecs[i].d2, vecs[i].resp, vecs[i].exp_strb);
            else
                do_read(vecs[i].addr, vecs[i].size, vecs[i].d0, vecs[i].d1, vecs[i].data,
                        vecs[i].resp, vecs[i].hold);
        end

        // Asynchronous reset while waiting in the write response phase
        req = 1'b1; wr = 1'b1; addr = 32'h0000_0040; size = 2'd2; wdata_i = 32'h7777_8888;
        #1 check("rstseq_addr_ok", addr_ok, 1);
        tick();
        req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1 check("rstseq_valids", {awvalid, wvalid}, 2'b11);
        tick();
        awready = 1'b0; wready = 1'b0;
        #1 check("rstseq_bready", bready, 1);
        #2 rst = 1'b1;
        #1;
        exp_bus_err = 1'b0;
        check("rstseq_ctrl", {arvalid, awvalid, wvalid, rready, bready, data_ok}, 0);
        check("rstseq_bus_err", bus_err, 0);
        check("rstseq_rdata_o", rdata_o, 0);
        req = 1'b1;
        #1 check("rstseq_idle", addr_ok, 1);
        req = 1'b0;
        #1 rst = 1'b0;
        do_read(32'h1FC0_0008, 2'd2, 0, 0, 32'h0BAD_F00D, 2'b00, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d;
            logic [1:0]  sz, resp;
            a    = $urandom;
            d    = $urandom;
            sz   = 2'($urandom_range(0, 3));
            resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 1)
                do_write(a, sz, d, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), resp, ref_strb(sz, a[1:0]));
            else
                do_read(a, sz, $urandom_range(0, 3), $urandom_range(0, 3), d, resp, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
